// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore sequencing FSM with ALU and immediate decoders for the multicycle RISC-V core
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       stall,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_e     state_q;
    state_e     state_d;

    // Raw per-state controls before stall/reset qualification
    logic [1:0] aluop;
    logic       irwrite_raw;
    logic       pcupdate;
    logic       branch;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic       done_raw;
    logic       illegal_raw;
    logic       wr_ok;

    // Next-state selection; a stall freezes the sequence wherever it is
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                S_FETCH:    state_d = S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTER;
                        OP_ITYPE:     state_d = S_EXECUTEI;
                        OP_JAL:       state_d = S_JAL;
                        OP_BEQ:       state_d = S_BEQ;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (op == OP_LW) begin
                        state_d = S_MEMREAD;
                    end else if (op == OP_SW) begin
                        state_d = S_MEMWRITE;
                    end else begin
                        // IR cannot change after DECODE, so this only guards odd encodings
                        state_d = S_FETCH;
                    end
                end
                S_MEMREAD:  state_d = S_MEMWB;
                S_MEMWB:    state_d = S_FETCH;
                S_MEMWRITE: state_d = S_FETCH;
                S_EXECUTER: state_d = S_ALUWB;
                S_EXECUTEI: state_d = S_ALUWB;
                S_ALUWB:    state_d = S_FETCH;
                S_JAL:      state_d = S_ALUWB;
                S_BEQ:      state_d = S_FETCH;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    // State register; reset returns to FETCH immediately, abandoning any instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode of the current state
    always_comb begin
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        resultsrc    = 2'b00;
        adrsrc       = 1'b0;
        aluop        = 2'b00;
        irwrite_raw  = 1'b0;
        pcupdate     = 1'b0;
        branch       = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        done_raw     = 1'b0;
        illegal_raw  = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                pcupdate    = 1'b1;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: illegal_raw = 1'b0;
                    default:                                          illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
            end
            S_MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc       = 1'b1;
                memwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            S_BEQ: begin
                alusrca  = 2'b10;
                aluop    = 2'b01;
                branch   = 1'b1;
                done_raw = 1'b1;
            end
            default: begin
                alusrca = 2'b00;
            end
        endcase
    end

    // Write enables only leave the block when out of reset and the memory is ready
    assign wr_ok      = reset_n & ~stall;
    assign irwrite    = irwrite_raw & wr_ok;
    assign pcwrite    = (pcupdate | (branch & zero)) & wr_ok;
    assign regwrite   = regwrite_raw & wr_ok;
    assign memwrite   = memwrite_raw & wr_ok;
    assign instr_done = done_raw & wr_ok;
    assign illegal    = illegal_raw & reset_n;
    assign state      = state_q;

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // ALU operation from aluop and the function fields; op[5] separates R-type sub from addi
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            2'b00: alucontrol = ALU_ADD;
            2'b01: alucontrol = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alucontrol = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       stall;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    // {state[3:0], ir,pc,reg,mem,done,ill, adrsrc, immsrc[2], alusrca[2], alusrcb[2], resultsrc[2], alucontrol[3]}
    logic [21:0] sbq[$];
    string       tagq[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .stall      (stall),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] st, input logic [5:0] en,
                        input logic adr, input logic [1:0] imm, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [1:0] rs, input logic [2:0] alu);
        sbq.push_back({st, en, adr, imm, sa, sb, rs, alu});
        tagq.push_back(tag);
    endtask

    task automatic step();
        logic [21:0] e;
        logic [17:0] obs;
        string       t;
        @(negedge clk);
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty state=%0d", state);
        end else begin
            e = sbq.pop_front();
            t = tagq.pop_front();
            obs = {irwrite, pcwrite, regwrite, memwrite, instr_done, illegal, adrsrc,
                   immsrc, alusrca, alusrcb, resultsrc, alucontrol};
            total++;
            assert (state === e[21:18]) else begin
                bad++;
                $error("FAIL %s state got=%0d exp=%0d", t, state, e[21:18]);
            end
            total++;
            assert (obs === e[17:0]) else begin
                bad++;
                $error("FAIL %s ctrl got=%b exp=%b", t, obs, e[17:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic exp_fetch(input logic [1:0] imm);
        push("fetch", 4'd0, 6'b110000, 1'b0, imm, 2'b00, 2'b10, 2'b10, 3'b000);
    endtask

    task automatic exp_decode(input logic [1:0] imm);
        push("decode", 4'd1, 6'b000000, 1'b0, imm, 2'b01, 2'b01, 2'b00, 3'b000);
    endtask

    task automatic exp_aluwb(input logic [1:0] imm);
        push("aluwb", 4'd7, 6'b001010, 1'b0, imm, 2'b00, 2'b00, 2'b00, 3'b000);
    endtask

    task automatic exp_reset();
        push("reset", 4'd0, 6'b000000, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        op       = 7'b0110011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        stall    = 1'b0;

        // reset held for three cycles with an R-type opcode present
        for (int i = 0; i < 3; i++) exp_reset();
        run(3);
        reset_n  = 1'b1;
        funct7b5 = 1'b1;

        // R-type sub, and, slt
        exp_fetch(2'b00); exp_decode(2'b00);
        push("exec_r_sub", 4'd6, 6'b000000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
        exp_aluwb(2'b00);
        run(4);
        funct3 = 3'b111;
        exp_fetch(2'b00); exp_decode(2'b00);
        push("exec_r_and", 4'd6, 6'b000000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010);
        exp_aluwb(2'b00);
        run(4);
        funct3 = 3'b010;
        exp_fetch(2'b00); exp_decode(2'b00);
        push("exec_r_slt", 4'd6, 6'b000000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101);
        exp_aluwb(2'b00);
        run(4);

        // addi with funct7b5 set must still add since op[5]=0
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        exp_fetch(2'b00); exp_decode(2'b00);
        push("exec_i_add", 4'd8, 6'b000000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
        exp_aluwb(2'b00);
        run(4);

        // lw: 0,1,2,3,4
        op = 7'b0000011; funct7b5 = 1'b0;
        exp_fetch(2'b00); exp_decode(2'b00);
        push("lw_memadr", 4'd2, 6'b000000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
        push("lw_memread", 4'd3, 6'b000000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        push("lw_memwb", 4'd4, 6'b001010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
        run(5);

        // sw: 0,1,2,5
        op = 7'b0100011;
        exp_fetch(2'b01); exp_decode(2'b01);
        push("sw_memadr", 4'd2, 6'b000000, 1'b0, 2'b01, 2'b10, 2'b01, 2'b00, 3'b000);
        push("sw_memwrite", 4'd5, 6'b000110, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
        run(4);

        // beq taken and not taken
        op = 7'b1100011; zero = 1'b1;
        exp_fetch(2'b10); exp_decode(2'b10);
        push("beq_taken", 4'd10, 6'b010010, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 3'b001);
        run(3);
        zero = 1'b0;
        exp_fetch(2'b10); exp_decode(2'b10);
        push("beq_not_taken", 4'd10, 6'b000010, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 3'b001);
        run(3);

        // jal: 0,1,9,7
        op = 7'b1101111;
        exp_fetch(2'b11); exp_decode(2'b11);
        push("jal", 4'd9, 6'b010000, 1'b0, 2'b11, 2'b01, 2'b10, 2'b00, 3'b000);
        exp_aluwb(2'b11);
        run(4);

        // illegal opcode: flag in DECODE, back to FETCH
        op = 7'b1111111;
        exp_fetch(2'b00);
        push("illegal_decode", 4'd1, 6'b000001, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
        run(2);

        // lw with two stalled cycles in MEMREAD: 7 cycles
        op = 7'b0000011;
        exp_fetch(2'b00); exp_decode(2'b00);
        push("stall_memadr", 4'd2, 6'b000000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
        run(3);
        stall = 1'b1;
        push("stall_memread1", 4'd3, 6'b000000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        push("stall_memread2", 4'd3, 6'b000000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        run(2);
        stall = 1'b0;
        push("stall_memread3", 4'd3, 6'b000000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
        push("stall_memwb", 4'd4, 6'b001010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
        run(2);

        // stall in FETCH suppresses irwrite/pcwrite and holds the state
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        stall = 1'b1;
        push("fetch_stall", 4'd0, 6'b000000, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000);
        run(1);
        stall = 1'b0;

        // reset arriving in ALUWB abandons the instruction with no write
        exp_fetch(2'b00); exp_decode(2'b00);
        push("exec_r_add", 4'd6, 6'b000000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000);
        run(3);
        reset_n = 1'b0;
        exp_reset(); exp_reset();
        run(2);
        reset_n = 1'b1;
        exp_fetch(2'b00);
        run(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle RISC-V core: a Moore main FSM plus combinational ALU and immediate decoders. It drives the shared datapath (PC, instruction register, single memory port, register file, ALU, and the `extend` unit via `immsrc`) across several cycles per instruction. It replaces the single-cycle control unit when the core is built in its multicycle configuration.

## Interface
- No parameters. Opcode and state encodings are fixed (below).
- `clk` in 1 — rising-edge clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `op` in 7 — `instr[6:0]` from the instruction register.
- `funct3` in 3 — `instr[14:12]`.
- `funct7b5` in 1 — `instr[30]`.
- `zero` in 1 — ALU zero flag.
- `stall` in 1 — memory not ready; hold the current state.
- `immsrc` out 2 — to `extend`: 00 I, 01 S, 10 B, 11 J.
- `alusrca` out 2 — 00 PC, 01 OldPC, 10 rd1 (A).
- `alusrcb` out 2 — 00 rd2, 01 immext, 10 constant 4.
- `resultsrc` out 2 — 00 ALUOut, 01 Data, 10 ALUResult.
- `adrsrc` out 1 — memory address: 0 PC, 1 Result.
- `alucontrol` out 3 — 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `irwrite`, `pcwrite`, `regwrite`, `memwrite` out 1 each — write enables.
- `instr_done` out 1 — high in the final state of each instruction.
- `illegal` out 1 — high in DECODE when `op` is unsupported.
- `state` out 4 — current state, for debug.

## Operation
- States, encoded 0–10:
  - FETCH
  - DECODE
  - MEMADR
  - MEMREAD
  - MEMWB
  - MEMWRITE
  - EXECUTER
  - ALUWB
  - EXECUTEI
  - JAL
  - BEQ
- Per-state outputs. Unlisted enables are 0; unlisted selects are 00.
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1. Next: DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=00. Next by `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - other → FETCH, with `illegal`=1 this cycle
  - MEMADR: alusrca=10, alusrcb=01. Next: MEMREAD if `op`=lw, MEMWRITE if `op`=sw.
  - MEMREAD: resultsrc=00, adrsrc=1. Next: MEMWB.
  - MEMWB: resultsrc=01, regwrite=1, instr_done. Next: FETCH.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1, instr_done. Next: FETCH.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10. Next: ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10. Next: ALUWB.
  - ALUWB: resultsrc=00, regwrite=1, instr_done. Next: FETCH.
  - JAL: alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1. Next: ALUWB.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, instr_done. Next: FETCH.
- `pcwrite` = pcupdate | (branch & zero).
- `immsrc` is decoded from `op` in every state: lw/addi-class → 00, sw → 01, beq → 10, jal → 11, all other opcodes → 00.
- ALU decoder:
  - aluop 00 → add.
  - aluop 01 → sub.
  - aluop 10, by `funct3`:
    - 000 → sub if (`op[5]` & `funct7b5`), else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - others → add
- `stall`=1 holds `state` unchanged and forces all four write enables and `instr_done` to 0. Select outputs still reflect the held state.

## Timing
- `reset_n`=0 asynchronously forces `state`=FETCH.
  - While `reset_n` is low, all write enables, `instr_done` and `illegal` are 0.
  - Selects show FETCH values: alusrcb=10, resultsrc=10, others 00; `alucontrol`=000.
- The first FETCH write enables assert in the first cycle after `reset_n` rises.
- A reset in the middle of an instruction abandons it; no write enable is asserted after the asynchronous assertion of reset.
- All outputs are combinational from `state`, `op`, `funct3`, `funct7b5`, `zero` and `stall`; there are no registered outputs except `state`.
- Cycles per instruction with no stall:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-ALU: 4
  - jal: 4
  - beq: 3
  - illegal: 2
- Each stalled cycle adds 1 cycle, at any state.
- `op` is sampled in DECODE and MEMADR. IR contents are valid from DECODE onward because `irwrite` is active only in FETCH.

## Test plan
- Reset behaviour: hold `reset_n`=0 for 3 cycles with `op`=0110011.
  - Expect `state`=0 and all enables 0.
  - After release, expect FETCH outputs with irwrite=1 and pcwrite=1.
- lw (`op`=0000011):
  - Expect the state trace 0,1,2,3,4,0.
  - `regwrite` is high only in state 4, with resultsrc=01.
  - `immsrc`=00 throughout.
- sw (`op`=0100011):
  - Expect the trace 0,1,2,5,0, with memwrite=1 and adrsrc=1 in state 5.
  - `immsrc`=01.
- R-type sub (`op`=0110011, funct3=000, funct7b5=1):
  - Expect `alucontrol`=001 in EXECUTER.
  - With funct3=111, expect 010.
  - With funct3=010, expect 101.
- beq (`op`=1100011, `immsrc`=10):
  - With `zero`=1, expect pcwrite=1 in BEQ.
  - With `zero`=0, expect pcwrite=0. Both cases return to FETCH.
- Stall, illegal opcode and jal:
  - Asserting `stall` for 2 cycles in MEMREAD holds `state`=3 with enables at 0; lw then takes 7 cycles.
  - `op`=1111111 gives `illegal`=1 in DECODE, then FETCH.
  - jal gives `immsrc`=11 and the trace 0,1,9,7,0.
